// File: rtl/adc_capture_pkg.sv
// Shared state encodings and default widths for the ADC capture controller.
package adc_capture_pkg;

    localparam int CTR_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/adc_noise_tmr.sv
// Square-wave generator for the receive-switch toggle used during noise measurement.
module adc_noise_tmr #(
    parameter int NOISE_HALF = 1524
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tgl
);

    localparam int CW = (NOISE_HALF > 0) ? $clog2(NOISE_HALF + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(NOISE_HALF);

    logic [CW-1:0] r_cnt;
    logic          r_tgl;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt <= RELOAD;
            r_tgl <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
            r_tgl <= ~r_tgl;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Gated so the output drops in the same cycle the mode is left.
    assign o_tgl = r_tgl & i_en;

endmodule

// File: rtl/adc_capture_ctl.sv
// ADC capture sequencer: arm on DMA request, wait for trigger plus delay,
// capture a bounded or unbounded number of beats, then hand back to idle.
module adc_capture_ctl
    import adc_capture_pkg::*;
#(
    parameter int CTR_W      = CTR_W_DEF,
    parameter int NOISE_HALF = 1524
) (
    input  logic             adc_clk,
    input  logic             adc_rst,
    input  logic             xfer_req,
    input  logic             dac_txed,
    input  logic             meas_noise,
    input  logic             done_req,
    input  logic [CTR_W-1:0] cap_len,
    input  logic [15:0]      trig_dly,
    input  logic             adc_dwr,
    input  logic             adc_wovf,
    output logic             adc_en,
    output logic             fifo_rst,
    output logic             rxq_sw_ctl,
    output logic [2:0]       state,
    output logic [CTR_W-1:0] beat_cnt,
    output logic             ovf_flag
);

    state_t             r_state;
    state_t             w_next;
    logic               r_live;
    logic               r_xfer_d;
    logic               r_dac_d;
    logic [15:0]        r_dly;
    logic [15:0]        r_trig_dly;
    logic [CTR_W-1:0]   r_cap_len;
    logic [CTR_W-1:0]   r_beat_cnt;
    logic               r_adc_en;
    logic               r_fifo_rst;
    logic               r_ovf;
    logic               w_xfer_rise;
    logic               w_trig;
    logic               w_last;
    logic               w_arm_entry;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (&v) ? v : v + CTR_W'(1);
    endfunction

    // r_live masks the first post-reset cycle so a request already high is not seen as an edge.
    assign w_xfer_rise = xfer_req & ~r_xfer_d & r_live;
    assign w_trig      = (dac_txed & ~r_dac_d & r_live) | meas_noise;
    assign w_last      = (r_cap_len != '0) && (r_beat_cnt == r_cap_len - CTR_W'(1));
    assign w_arm_entry = (r_state == ST_IDLE) && w_xfer_rise;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_xfer_rise) w_next = ST_ARMED;
            ST_ARMED: begin
                if (done_req)       w_next = ST_DONE;
                else if (!xfer_req) w_next = ST_IDLE;
                else if (w_trig)    w_next = ST_DELAY;
            end
            ST_DELAY: begin
                if (done_req)           w_next = ST_DONE;
                else if (!xfer_req)     w_next = ST_IDLE;
                else if (r_dly == '0)   w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (done_req)               w_next = ST_DONE;
                else if (!xfer_req)         w_next = ST_IDLE;
                else if (adc_dwr && w_last) w_next = ST_DONE;
            end
            ST_DONE:    if (!xfer_req && !done_req) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_xfer_d   <= 1'b0;
            r_dac_d    <= 1'b0;
            r_dly      <= '0;
            r_beat_cnt <= '0;
            r_adc_en   <= 1'b0;
            r_fifo_rst <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_live     <= 1'b1;
            r_xfer_d   <= xfer_req;
            r_dac_d    <= dac_txed;
            r_adc_en   <= (w_next == ST_CAPTURE);
            r_fifo_rst <= w_arm_entry;
            if (w_arm_entry) begin
                r_beat_cnt <= '0;
                r_ovf      <= 1'b0;
            end else if (r_state == ST_CAPTURE) begin
                if (adc_dwr)  r_beat_cnt <= sat_inc(r_beat_cnt);
                if (adc_wovf) r_ovf      <= 1'b1;
            end
            if (r_state == ST_ARMED)
                r_dly <= r_trig_dly;
            else if (r_state == ST_DELAY && r_dly != '0)
                r_dly <= r_dly - 16'd1;
        end
    end

    // Run parameters are frozen at arm time so software may reprogram mid-run.
    always_ff @(posedge adc_clk) begin
        if (w_arm_entry) begin
            r_cap_len  <= cap_len;
            r_trig_dly <= trig_dly;
        end
    end

    adc_noise_tmr #(
        .NOISE_HALF (NOISE_HALF)
    ) u_noise_tmr (
        .i_clk (adc_clk),
        .i_rst (adc_rst),
        .i_en  (meas_noise),
        .o_tgl (rxq_sw_ctl)
    );

    assign adc_en   = r_adc_en;
    assign fifo_rst = r_fifo_rst;
    assign state    = r_state;
    assign beat_cnt = r_beat_cnt;
    assign ovf_flag = r_ovf;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// Directed-vector bench for adc_capture_ctl with hand-computed expectations.
module tb_adc_capture_ctl;

    localparam int CW = 24;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic          adc_clk = 1'b0;
    logic          adc_rst;
    logic          xfer_req;
    logic          dac_txed;
    logic          meas_noise;
    logic          done_req;
    logic [CW-1:0] cap_len;
    logic [15:0]   trig_dly;
    logic          adc_dwr;
    logic          adc_wovf;
    logic          adc_en;
    logic          fifo_rst;
    logic          rxq_sw_ctl;
    logic [2:0]    state;
    logic [CW-1:0] beat_cnt;
    logic          ovf_flag;

    int total = 0;
    int bad = 0;

    always #5 adc_clk = ~adc_clk;

    adc_capture_ctl #(
        .CTR_W      (CW),
        .NOISE_HALF (3)
    ) dut (
        .adc_clk    (adc_clk),
        .adc_rst    (adc_rst),
        .xfer_req   (xfer_req),
        .dac_txed   (dac_txed),
        .meas_noise (meas_noise),
        .done_req   (done_req),
        .cap_len    (cap_len),
        .trig_dly   (trig_dly),
        .adc_dwr    (adc_dwr),
        .adc_wovf   (adc_wovf),
        .adc_en     (adc_en),
        .fifo_rst   (fifo_rst),
        .rxq_sw_ctl (rxq_sw_ctl),
        .state      (state),
        .beat_cnt   (beat_cnt),
        .ovf_flag   (ovf_flag)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic arm(input logic [CW-1:0] cl, input logic [15:0] td);
        cap_len = cl;
        trig_dly = td;
        xfer_req = 1'b0;
        dac_txed = 1'b0;
        done_req = 1'b0;
        adc_dwr = 1'b0;
        adc_wovf = 1'b0;
        meas_noise = 1'b0;
        step(1);
        xfer_req = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        adc_rst = 1'b1;
        xfer_req = 1'b1;
        dac_txed = 1'b0;
        meas_noise = 1'b0;
        done_req = 1'b0;
        adc_dwr = 1'b0;
        adc_wovf = 1'b0;
        cap_len = '0;
        trig_dly = '0;
        step(3);
        total++;
        if ({state, adc_en, fifo_rst, rxq_sw_ctl, ovf_flag} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got st=%0d en=%b fr=%b rxq=%b ovf=%b want all 0", state, adc_en, fifo_rst, rxq_sw_ctl, ovf_flag);
        end
        total++;
        if (beat_cnt !== '0) begin
            bad++;
            $display("FAIL reset_beat: got %0d want 0", beat_cnt);
        end
        adc_rst = 1'b0;
        step(3);
        total++;
        if (state !== S_IDLE || fifo_rst !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_arm: got st=%0d fr=%b want st=0 fr=0", state, fifo_rst);
        end
        xfer_req = 1'b0;
        step(1);
    endtask

    task automatic test_basic;
        int en_cyc;
        int dwr_en;
        arm(8, 0);
        total++;
        if (state !== S_ARMED || fifo_rst !== 1'b1 || beat_cnt !== '0) begin
            bad++;
            $display("FAIL basic_arm: got st=%0d fr=%b beat=%0d want st=1 fr=1 beat=0", state, fifo_rst, beat_cnt);
        end
        step(1);
        total++;
        if (fifo_rst !== 1'b0 || state !== S_ARMED) begin
            bad++;
            $display("FAIL basic_fifo_pulse: got fr=%b st=%0d want fr=0 st=1", fifo_rst, state);
        end
        dac_txed = 1'b1;
        step(1);
        total++;
        if (state !== S_DELAY) begin
            bad++;
            $display("FAIL basic_delay: got %0d want 2", state);
        end
        step(1);
        total++;
        if (state !== S_CAPTURE || adc_en !== 1'b1) begin
            bad++;
            $display("FAIL basic_capture: got st=%0d en=%b want st=3 en=1", state, adc_en);
        end
        en_cyc = 1;
        dwr_en = 0;
        for (int i = 0; i < 60; i++) begin
            adc_dwr = (i % 4 == 3);
            if (adc_dwr && adc_en) dwr_en++;
            step(1);
            if (adc_en) en_cyc++;
            if (state == S_DONE) break;
        end
        adc_dwr = 1'b0;
        total++;
        if (state !== S_DONE || beat_cnt !== 24'd8 || adc_en !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: got st=%0d beat=%0d en=%b want st=4 beat=8 en=0", state, beat_cnt, adc_en);
        end
        total++;
        if (dwr_en !== 8 || en_cyc !== 32) begin
            bad++;
            $display("FAIL basic_en_window: got beats=%0d cycles=%0d want beats=8 cycles=32", dwr_en, en_cyc);
        end
    endtask

    task automatic test_done_exit;
        done_req = 1'b1;
        xfer_req = 1'b0;
        step(1);
        total++;
        if (state !== S_DONE) begin
            bad++;
            $display("FAIL done_hold_req: got %0d want 4", state);
        end
        xfer_req = 1'b1;
        step(1);
        total++;
        if (state !== S_DONE || fifo_rst !== 1'b0) begin
            bad++;
            $display("FAIL done_ignore_edge: got st=%0d fr=%b want st=4 fr=0", state, fifo_rst);
        end
        done_req = 1'b0;
        step(1);
        total++;
        if (state !== S_DONE) begin
            bad++;
            $display("FAIL done_hold_xfer: got %0d want 4", state);
        end
        xfer_req = 1'b0;
        step(1);
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL done_exit: got %0d want 0", state);
        end
    endtask

    task automatic test_delay;
        int pulses;
        arm(4, 5);
        total++;
        if (state !== S_ARMED || fifo_rst !== 1'b1) begin
            bad++;
            $display("FAIL dly_arm: got st=%0d fr=%b want st=1 fr=1", state, fifo_rst);
        end
        trig_dly = 16'd1;
        cap_len = 24'd2;
        step(1);
        dac_txed = 1'b1;
        step(1);
        total++;
        if (state !== S_DELAY) begin
            bad++;
            $display("FAIL dly_enter: got %0d want 2", state);
        end
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (fifo_rst) pulses++;
            total++;
            if (adc_en !== 1'b0 || state !== S_DELAY) begin
                bad++;
                $display("FAIL dly_wait%0d: got st=%0d en=%b want st=2 en=0", k, state, adc_en);
            end
        end
        step(1);
        total++;
        if (adc_en !== 1'b1 || state !== S_CAPTURE || pulses !== 0) begin
            bad++;
            $display("FAIL dly_start: got st=%0d en=%b pulses=%0d want st=3 en=1 pulses=0", state, adc_en, pulses);
        end
        adc_dwr = 1'b1;
        step(4);
        adc_dwr = 1'b0;
        total++;
        if (state !== S_DONE || beat_cnt !== 24'd4 || adc_en !== 1'b0) begin
            bad++;
            $display("FAIL dly_caplen_sampled: got st=%0d beat=%0d en=%b want st=4 beat=4 en=0", state, beat_cnt, adc_en);
        end
        xfer_req = 1'b0;
        dac_txed = 1'b0;
        step(1);
    endtask

    task automatic test_done_prio;
        arm(100, 0);
        dac_txed = 1'b1;
        step(1);
        dac_txed = 1'b0;
        step(1);
        adc_dwr = 1'b1;
        step(10);
        adc_dwr = 1'b0;
        total++;
        if (state !== S_CAPTURE || beat_cnt !== 24'd10) begin
            bad++;
            $display("FAIL prio_beats: got st=%0d beat=%0d want st=3 beat=10", state, beat_cnt);
        end
        done_req = 1'b1;
        dac_txed = 1'b1;
        step(1);
        total++;
        if (state !== S_DONE || beat_cnt !== 24'd10 || adc_en !== 1'b0) begin
            bad++;
            $display("FAIL prio_capture_done: got st=%0d beat=%0d en=%b want st=4 beat=10 en=0", state, beat_cnt, adc_en);
        end
        done_req = 1'b0;
        xfer_req = 1'b0;
        dac_txed = 1'b0;
        step(1);
        arm(5, 0);
        done_req = 1'b1;
        dac_txed = 1'b1;
        step(1);
        total++;
        if (state !== S_DONE) begin
            bad++;
            $display("FAIL prio_armed_done: got %0d want 4", state);
        end
        done_req = 1'b0;
        xfer_req = 1'b0;
        dac_txed = 1'b0;
        step(1);
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL prio_exit: got %0d want 0", state);
        end
    endtask

    task automatic test_abort;
        arm(0, 0);
        dac_txed = 1'b1;
        step(2);
        adc_dwr = 1'b1;
        step(3);
        adc_dwr = 1'b0;
        xfer_req = 1'b0;
        step(1);
        total++;
        if (state !== S_IDLE || adc_en !== 1'b0 || beat_cnt !== 24'd3) begin
            bad++;
            $display("FAIL abort_idle: got st=%0d en=%b beat=%0d want st=0 en=0 beat=3", state, adc_en, beat_cnt);
        end
        arm(0, 0);
        total++;
        if (state !== S_ARMED || beat_cnt !== '0) begin
            bad++;
            $display("FAIL abort_rearm_clear: got st=%0d beat=%0d want st=1 beat=0", state, beat_cnt);
        end
        dac_txed = 1'b1;
        step(2);
        adc_dwr = 1'b1;
        adc_wovf = 1'b1;
        step(2);
        adc_dwr = 1'b0;
        adc_wovf = 1'b0;
        total++;
        if (state !== S_CAPTURE || beat_cnt !== 24'd2 || ovf_flag !== 1'b1) begin
            bad++;
            $display("FAIL abort_precond: got st=%0d beat=%0d ovf=%b want st=3 beat=2 ovf=1", state, beat_cnt, ovf_flag);
        end
        adc_rst = 1'b1;
        step(1);
        total++;
        if ({state, adc_en, fifo_rst, rxq_sw_ctl, ovf_flag} !== 7'b0 || beat_cnt !== '0) begin
            bad++;
            $display("FAIL abort_reset: got st=%0d en=%b fr=%b rxq=%b ovf=%b beat=%0d want all 0", state, adc_en, fifo_rst, rxq_sw_ctl, ovf_flag, beat_cnt);
        end
        adc_rst = 1'b0;
        step(2);
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL abort_post_reset: got %0d want 0", state);
        end
        xfer_req = 1'b0;
        dac_txed = 1'b0;
        step(1);
    endtask

    task automatic test_ovf;
        arm(3, 0);
        adc_wovf = 1'b1;
        step(1);
        adc_wovf = 1'b0;
        total++;
        if (ovf_flag !== 1'b0 || state !== S_ARMED) begin
            bad++;
            $display("FAIL ovf_armed_ignored: got ovf=%b st=%0d want ovf=0 st=1", ovf_flag, state);
        end
        dac_txed = 1'b1;
        step(2);
        adc_wovf = 1'b1;
        step(1);
        adc_wovf = 1'b0;
        total++;
        if (ovf_flag !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got %b want 1", ovf_flag);
        end
        adc_dwr = 1'b1;
        step(3);
        adc_dwr = 1'b0;
        total++;
        if (state !== S_DONE || ovf_flag !== 1'b1) begin
            bad++;
            $display("FAIL ovf_done: got st=%0d ovf=%b want st=4 ovf=1", state, ovf_flag);
        end
        xfer_req = 1'b0;
        step(1);
        total++;
        if (state !== S_IDLE || ovf_flag !== 1'b1) begin
            bad++;
            $display("FAIL ovf_idle_hold: got st=%0d ovf=%b want st=0 ovf=1", state, ovf_flag);
        end
        arm(3, 0);
        total++;
        if (ovf_flag !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear_on_arm: got %b want 0", ovf_flag);
        end
        xfer_req = 1'b0;
        step(1);
    endtask

    task automatic test_noise;
        logic exp_rxq;
        total++;
        if (rxq_sw_ctl !== 1'b0) begin
            bad++;
            $display("FAIL noise_off: got %b want 0", rxq_sw_ctl);
        end
        arm(0, 2);
        meas_noise = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            exp_rxq = ((i / 4) % 2) == 1;
            total++;
            if (rxq_sw_ctl !== exp_rxq) begin
                bad++;
                $display("FAIL noise_tgl%0d: got %b want %b", i, rxq_sw_ctl, exp_rxq);
            end
            if (i == 1) begin
                total++;
                if (state !== S_DELAY) begin
                    bad++;
                    $display("FAIL noise_trigger: got %0d want 2", state);
                end
            end
            if (i == 4) begin
                total++;
                if (state !== S_CAPTURE || adc_en !== 1'b1) begin
                    bad++;
                    $display("FAIL noise_capture: got st=%0d en=%b want st=3 en=1", state, adc_en);
                end
            end
        end
        meas_noise = 1'b0;
        step(1);
        total++;
        if (rxq_sw_ctl !== 1'b0 || state !== S_CAPTURE) begin
            bad++;
            $display("FAIL noise_stop: got rxq=%b st=%0d want rxq=0 st=3", rxq_sw_ctl, state);
        end
        xfer_req = 1'b0;
        step(1);
        total++;
        if (state !== S_IDLE || adc_en !== 1'b0) begin
            bad++;
            $display("FAIL noise_exit: got st=%0d en=%b want st=0 en=0", state, adc_en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_done_exit();
        test_delay();
        test_done_prio();
        test_abort();
        test_ovf();
        test_noise();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctl.md
ADC_CAPTURE_CTL -- requirements
Module: adc_capture_ctl

Interface
REQ-001 SHALL have parameter CTR_W, default 24, width of the capture-length and beat counters.
REQ-002 SHALL have parameter NOISE_HALF, default 1524, rxq_sw_ctl half-period in adc_clk cycles, minus 1.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 adc_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 adc_rst  in  1  synchronous active-high reset.
REQ-006 xfer_req  in  1  DMA transfer request, already synchronised to adc_clk.
REQ-007 dac_txed  in  1  DAC transmit window, already synchronised to adc_clk.
REQ-008 meas_noise  in  1  noise-measurement mode (level).
REQ-009 done_req  in  1  software abort/finish (level).
REQ-010 cap_len  in  CTR_W  beats to capture; 0 = unlimited.
REQ-011 trig_dly  in  16  cycles from trigger to capture start.
REQ-012 adc_dwr  in  1  wide-word beat strobe from the width converter.
REQ-013 adc_wovf  in  1  overflow from the width converter.
REQ-014 adc_en  out  1  capture enable to the write path.
REQ-015 fifo_rst  out  1  one-cycle write-path reset pulse.
REQ-016 rxq_sw_ctl  out  1  noise-mode switch toggle.
REQ-017 state  out  3  current FSM state code.
REQ-018 beat_cnt  out  CTR_W  beats captured in the current run.
REQ-019 ovf_flag  out  1  sticky overflow seen during CAPTURE.

Function
REQ-020 FSM states SHALL be IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4; all other codes SHALL return to IDLE on the next cycle.
REQ-021 IDLE->ARMED on an xfer_req rising edge (registered edge detect); fifo_rst SHALL pulse high on the same cycle state becomes ARMED; beat_cnt and ovf_flag SHALL clear on that cycle.
REQ-022 ARMED->DELAY on trigger = (dac_txed rising edge) OR meas_noise; the delay counter SHALL load trig_dly.
REQ-023 DELAY SHALL decrement once per cycle; on reaching 0 -> CAPTURE; trig_dly=0 SHALL enter CAPTURE on the cycle after DELAY is entered.
REQ-024 adc_en SHALL be 1 exactly while state==CAPTURE (registered, same-cycle as state).
REQ-025 In CAPTURE, beat_cnt SHALL increment on each adc_dwr; when adc_dwr occurs with beat_cnt==cap_len-1 (cap_len!=0), next state SHALL be DONE and the terminating beat SHALL be counted.
REQ-026 cap_len=0: CAPTURE SHALL persist until done_req or xfer_req low; beat_cnt SHALL saturate at all-ones.
REQ-027 done_req high in ARMED, DELAY or CAPTURE SHALL force DONE next cycle; done_req SHALL take priority over trigger and terminal count in the same cycle.
REQ-028 xfer_req low in ARMED, DELAY or CAPTURE SHALL force IDLE next cycle (abort); beat_cnt SHALL hold.
REQ-029 DONE->IDLE when xfer_req is low and done_req is low; a new xfer_req edge while in DONE SHALL be ignored.
REQ-030 ovf_flag SHALL set on adc_wovf while in CAPTURE and hold until the next ARMED entry or reset.
REQ-031 rxq_sw_ctl SHALL be 0 while meas_noise is 0; while meas_noise is 1 it SHALL toggle every NOISE_HALF+1 cycles, counter reloading when meas_noise is 0.
REQ-032 cap_len and trig_dly SHALL be sampled on ARMED entry; later changes SHALL not affect the current run.

Reset
REQ-033 adc_rst SHALL force state=IDLE and adc_en=0, fifo_rst=0, rxq_sw_ctl=0, beat_cnt=0, ovf_flag=0, clear all edge-detect registers and counters, from any state including mid-CAPTURE.
REQ-034 An xfer_req already high when reset releases SHALL NOT arm; only a subsequent rising edge arms.

Structure
REQ-035 State encodings and the CTR_W default SHALL live in a shared package, adc_capture_pkg.
REQ-036 The noise-toggle timer SHALL be one sub-module, adc_noise_tmr; all other logic SHALL be in the top.

Verification
REQ-037 cap_len=8, trig_dly=0, xfer_req rise, dac_txed rise, adc_dwr every 4th cycle -> adc_en high for exactly 8 beats, beat_cnt=8, state=DONE.
REQ-038 trig_dly=5 -> adc_en rises exactly 6 cycles after the registered trigger edge; fifo_rst is a single pulse on ARMED entry.
REQ-039 cap_len=100, done_req asserted after beat 10 together with a dac_txed edge -> DONE next cycle, beat_cnt=10 or 11 per REQ-025, adc_en low.
REQ-040 xfer_req dropped mid-CAPTURE -> IDLE next cycle, adc_en=0; adc_rst mid-CAPTURE -> all outputs at reset values.
REQ-041 meas_noise=1, NOISE_HALF=3 -> rxq_sw_ctl toggles every 4 cycles and capture starts without dac_txed; meas_noise=0 -> rxq_sw_ctl=0.
REQ-042 adc_wovf pulse in CAPTURE -> ovf_flag=1 held through DONE, cleared on next ARMED.
